// File: rtl/rv32i_types.sv
// Shared RV32I types and constants; carries the instruction-cache state encoding and geometry.
package rv32i_types;

  localparam int unsigned ICACHE_SETS      = 16;
  localparam int unsigned ICACHE_LINE_BITS = 256;
  localparam int unsigned ICACHE_BEAT_BITS = 64;
  localparam int unsigned ICACHE_IDX_BITS  = 4;
  localparam int unsigned ICACHE_TAG_BITS  = 23;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    REFILL,
    WAIT,
    ALLOCATE
  } icache_state_t;

endpackage

// File: rtl/icache_refill_buf.sv
// Collects the four 64-bit refill beats of one line, in arrival order, ignoring beats for other lines.
module icache_refill_buf
  import rv32i_types::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        en,
  input  logic [31:0]                 line_addr,
  input  logic [31:0]                 bmem_raddr,
  input  logic [ICACHE_BEAT_BITS-1:0] bmem_rdata,
  input  logic                        bmem_rvalid,
  output logic [ICACHE_LINE_BITS-1:0] line,
  output logic                        done_c
);

  logic [1:0] beat_q;
  logic       take_c;

  assign take_c = en && bmem_rvalid && (bmem_raddr == line_addr);
  assign done_c = take_c && (beat_q == 2'd3);

  // Counter restarts whenever a new refill is requested so abandoned beats never leak in.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      beat_q <= 2'd0;
    end else if (take_c) begin
      beat_q <= 2'(beat_q + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (take_c) begin
      line[{beat_q, 6'b0} +: ICACHE_BEAT_BITS] <= bmem_rdata;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache: 16 sets of 256-bit lines refilled in four 64-bit beats.
module icache_dm
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  input  logic        imem_flush,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  icache_state_t state_q, state_d;
  logic [31:2]   addr_q, addr_d;
  logic          kill_q, kill_d;
  logic          resp_c, alloc_c, done_c, hit_c, req_c;

  logic [ICACHE_TAG_BITS-1:0]  tag_q   [ICACHE_SETS];
  logic [ICACHE_LINE_BITS-1:0] data_q  [ICACHE_SETS];
  logic [ICACHE_SETS-1:0]      valid_q;
  logic [ICACHE_LINE_BITS-1:0] fill_line;

  logic [ICACHE_IDX_BITS-1:0]  idx;
  logic [ICACHE_TAG_BITS-1:0]  tag;
  logic [31:0]                 line_addr;
  logic [1:0]                  unused_addr;

  assign unused_addr = imem_addr[1:0];
  assign idx         = addr_q[8:5];
  assign tag         = addr_q[31:9];
  assign line_addr   = {addr_q[31:5], 5'b0};
  assign hit_c       = valid_q[idx] && (tag_q[idx] == tag);
  assign req_c       = (imem_rmask != 4'b0);

  icache_refill_buf u_refill_buf (
    .clk         (clk),
    .rst         (rst),
    .start       (state_q == REFILL),
    .en          (state_q == WAIT),
    .line_addr   (line_addr),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .line        (fill_line),
    .done_c      (done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
    end
  end

  // Next state; a flush in COMPARE acts as a redirect, elsewhere in a refill it only kills the response.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    resp_c  = 1'b0;
    alloc_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          addr_d  = imem_addr[31:2];
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (imem_flush || hit_c) begin
          resp_c = !imem_flush;
          if (req_c) begin
            addr_d  = imem_addr[31:2];
            state_d = COMPARE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (imem_flush) kill_d = 1'b1;
        if (bmem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_flush) kill_d = 1'b1;
        if (done_c) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        alloc_c = 1'b1;
        kill_d  = 1'b0;
        state_d = (kill_q || imem_flush) ? IDLE : COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (alloc_c) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (alloc_c) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_line;
    end
  end

  assign imem_resp  = resp_c;
  assign imem_rdata = resp_c ? data_q[idx][{addr_q[4:2], 5'b0} +: 32] : 32'h0;
  assign bmem_read  = (state_q == REFILL);
  assign bmem_addr  = (state_q == REFILL) ? line_addr : 32'h0;

endmodule
